// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared types for the divide controller.
// Holds the FSM state enum, the req_op encodings, the latched request payload
// and helpers that decode an op and pick the quotient or remainder half.
package div_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned DOUT_W = 64;
  localparam int unsigned OP_W   = 2;

  // bit1 selects the unsigned IP, bit0 selects the remainder
  typedef enum logic [OP_W-1:0] {
    OP_DIV_W  = 2'b00,
    OP_MOD_W  = 2'b01,
    OP_DIV_WU = 2'b10,
    OP_MOD_WU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } div_state_e;

  typedef struct packed {
    div_op_e         op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
  } div_req_t;

  function automatic logic op_is_unsigned(div_op_e op);
    return (op == OP_DIV_WU) || (op == OP_MOD_WU);
  endfunction

  function automatic logic op_is_mod(div_op_e op);
    return (op == OP_MOD_W) || (op == OP_MOD_WU);
  endfunction

  // IP output layout is {quotient, remainder}
  function automatic logic [XLEN-1:0] sel_result(div_op_e op, logic [DOUT_W-1:0] dout);
    return op_is_mod(op) ? dout[XLEN-1:0] : dout[DOUT_W-1:XLEN];
  endfunction

endpackage

// File: rtl/div_result_cache.sv
// div_result_cache: single-entry memo of the last completed divide.
// Only built when DIV_RESULT_CACHE_EN is defined.
// Ports:
//   clk, resetn            clock, async active-low reset (entry invalidated)
//   wr_en_i                write the entry
//   wr_req_i, wr_result_i  request and selected result to store
//   lk_req_i               incoming request to look up
//   hit_c_o                combinational: valid entry matches lk_req_i
//   hit_result_c_o         stored result
module div_result_cache
  import div_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            wr_en_i,
  input  div_req_t        wr_req_i,
  input  logic [XLEN-1:0] wr_result_i,
  input  div_req_t        lk_req_i,
  output logic            hit_c_o,
  output logic [XLEN-1:0] hit_result_c_o
);

  logic            valid_q;
  div_req_t        tag_q;
  logic [XLEN-1:0] result_q;

  // Entry storage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q  <= 1'b0;
      tag_q    <= '0;
      result_q <= '0;
    end else if (wr_en_i) begin
      valid_q  <= 1'b1;
      tag_q    <= wr_req_i;
      result_q <= wr_result_i;
    end
  end

  assign hit_c_o        = valid_q && (tag_q == lk_req_i);
  assign hit_result_c_o = result_q;

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: sequences one divide at a time through a signed or unsigned
// divider IP, with flush handling so killed ops are drained, not reported.
// Optional feature: DIV_RESULT_CACHE_EN adds a one-entry result cache that
// answers a repeated request without touching the IP.
// Ports:
//   clk, resetn                       clock, async active-low reset
//   req_valid/req_ready/req_op/req_src1/req_src2   request from EXE
//   flush                             kill the in-flight op
//   resp_valid/resp_ready/resp_result response to EXE
//   busy                              controller not idle
//   div_dividend/div_divisor          operand bus shared by both IPs
//   sdiv_* / udiv_*                   signed / unsigned IP handshakes
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [XLEN-1:0]   req_src1,
  input  logic [XLEN-1:0]   req_src2,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_result,
  output logic              busy,
  output logic [XLEN-1:0]   div_dividend,
  output logic [XLEN-1:0]   div_divisor,
  output logic              sdiv_tvalid,
  input  logic              sdiv_tready,
  output logic              udiv_tvalid,
  input  logic              udiv_tready,
  input  logic              sdiv_dout_tvalid,
  input  logic [DOUT_W-1:0] sdiv_dout,
  input  logic              udiv_dout_tvalid,
  input  logic [DOUT_W-1:0] udiv_dout
);

  div_state_e      state_q, state_d;
  div_req_t        req_q, req_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            flush_seen_q, flush_seen_d;
  logic            sdiv_tvalid_q, udiv_tvalid_q;
  logic            busy_q, req_ready_q;

  logic              sel_uns_c;
  logic              tready_sel_c;
  logic              dout_valid_sel_c;
  logic [DOUT_W-1:0] dout_sel_c;
  div_req_t          in_req_c;

  // Route the handshakes of whichever IP the latched op targets
  assign sel_uns_c        = op_is_unsigned(req_q.op);
  assign tready_sel_c     = sel_uns_c ? udiv_tready      : sdiv_tready;
  assign dout_valid_sel_c = sel_uns_c ? udiv_dout_tvalid : sdiv_dout_tvalid;
  assign dout_sel_c       = sel_uns_c ? udiv_dout        : sdiv_dout;

  assign in_req_c = '{op: div_op_e'(req_op), src1: req_src1, src2: req_src2};

`ifdef DIV_RESULT_CACHE_EN
  logic            cache_hit_c;
  logic [XLEN-1:0] cache_result_c;
  logic            cache_wr_c;

  div_result_cache u_cache (
    .clk            (clk),
    .resetn         (resetn),
    .wr_en_i        (cache_wr_c),
    .wr_req_i       (req_q),
    .wr_result_i    (result_d),
    .lk_req_i       (in_req_c),
    .hit_c_o        (cache_hit_c),
    .hit_result_c_o (cache_result_c)
  );
`endif

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    result_d     = result_q;
    flush_seen_d = flush_seen_q;
`ifdef DIV_RESULT_CACHE_EN
    cache_wr_c   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // a request arriving with flush is already dead
        if (req_valid && req_ready_q && !flush) begin
          req_d        = in_req_c;
          flush_seen_d = 1'b0;
          state_d      = ST_ISSUE;
`ifdef DIV_RESULT_CACHE_EN
          if (cache_hit_c) begin
            result_d = cache_result_c;
            state_d  = ST_DONE;
          end
`endif
        end
      end
      ST_ISSUE: begin
        // tvalid cannot be withdrawn, so remember the flush until handshake
        if (flush) begin
          flush_seen_d = 1'b1;
        end
        if (tready_sel_c) begin
          state_d = (flush_seen_q || flush) ? ST_DRAIN : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dout_valid_sel_c) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            result_d = sel_result(req_q.op, dout_sel_c);
            state_d  = ST_DONE;
`ifdef DIV_RESULT_CACHE_EN
            cache_wr_c = 1'b1;
`endif
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (flush || resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (dout_valid_sel_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      req_q         <= '0;
      result_q      <= '0;
      flush_seen_q  <= 1'b0;
      sdiv_tvalid_q <= 1'b0;
      udiv_tvalid_q <= 1'b0;
      busy_q        <= 1'b0;
      req_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      result_q      <= result_d;
      flush_seen_q  <= flush_seen_d;
      sdiv_tvalid_q <= (state_d == ST_ISSUE) && !op_is_unsigned(req_d.op);
      udiv_tvalid_q <= (state_d == ST_ISSUE) &&  op_is_unsigned(req_d.op);
      busy_q        <= (state_d != ST_IDLE);
      req_ready_q   <= (state_d == ST_IDLE);
    end
  end

  assign req_ready    = req_ready_q;
  assign busy         = busy_q;
  assign sdiv_tvalid  = sdiv_tvalid_q;
  assign udiv_tvalid  = udiv_tvalid_q;
  assign div_dividend = req_q.src1;
  assign div_divisor  = req_q.src2;
  assign resp_result  = result_q;
  // a flush in DONE must suppress the response in the same cycle
  assign resp_valid   = (state_q == ST_DONE) && !flush;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: randomized and directed checks of div_ctrl against a
// behavioural divide model; the bench also plays both divider IPs.
module tb_div_ctrl;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        flush;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_result;
  logic        busy;
  logic [31:0] div_dividend, div_divisor;
  logic        sdiv_tvalid, sdiv_tready, udiv_tvalid, udiv_tready;
  logic        sdiv_dout_tvalid, udiv_dout_tvalid;
  logic [63:0] sdiv_dout, udiv_dout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  cur_op;
  logic [63:0] ip_dout;

  div_ctrl dut (
    .clk              (clk),
    .resetn           (resetn),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_src1         (req_src1),
    .req_src2         (req_src2),
    .flush            (flush),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_result      (resp_result),
    .busy             (busy),
    .div_dividend     (div_dividend),
    .div_divisor      (div_divisor),
    .sdiv_tvalid      (sdiv_tvalid),
    .sdiv_tready      (sdiv_tready),
    .udiv_tvalid      (udiv_tvalid),
    .udiv_tready      (udiv_tready),
    .sdiv_dout_tvalid (sdiv_dout_tvalid),
    .sdiv_dout        (sdiv_dout),
    .udiv_dout_tvalid (udiv_dout_tvalid),
    .udiv_dout        (udiv_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Divider IP behaviour: {quotient, remainder}; /0 and overflow have fixed answers
  function automatic logic [63:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[1]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] d;
    d = ref_div(op, a, b);
    return op[0] ? d[31:0] : d[63:32];
  endfunction

  function automatic logic sel_tvalid();
    return cur_op[1] ? udiv_tvalid : sdiv_tvalid;
  endfunction

  function automatic logic oth_tvalid();
    return cur_op[1] ? sdiv_tvalid : udiv_tvalid;
  endfunction

  // Offer a request in IDLE; returns one cycle after the accepting edge
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    cur_op = op;
    check_eq("ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    tick();
    req_valid = 1'b0;
    req_src1  = $urandom;
    req_src2  = $urandom;
    check_eq("tvalid_sel_t1", 64'(sel_tvalid()), 64'd1);
    check_eq("tvalid_other", 64'(oth_tvalid()), 64'd0);
    check_eq("operand_bus", {div_dividend, div_divisor}, {a, b});
    check_eq("busy_ready_issue", 64'({busy, req_ready}), 64'b10);
  endtask

  // IP accepts the operands after tr_dly cycles of tready low
  task automatic handshake(input int tr_dly);
    repeat (tr_dly) begin
      check_eq("tvalid_hold", 64'(sel_tvalid()), 64'd1);
      check_eq("tvalid_other_hold", 64'(oth_tvalid()), 64'd0);
      tick();
    end
    check_eq("tvalid_at_hs", 64'(sel_tvalid()), 64'd1);
    ip_dout = ref_div(cur_op, div_dividend, div_divisor);
    if (cur_op[1]) udiv_tready = 1'b1;
    else           sdiv_tready = 1'b1;
    tick();
    udiv_tready = 1'b0;
    sdiv_tready = 1'b0;
    check_eq("tvalid_after_hs", 64'({sdiv_tvalid, udiv_tvalid}), 64'd0);
  endtask

  // IP result appears lat cycles after the handshake; returns at dout+1
  task automatic deliver(input int lat);
    repeat (lat - 1) begin
      check_eq("no_early_resp", 64'(resp_valid), 64'd0);
      tick();
    end
    check_eq("no_resp_at_dout", 64'(resp_valid), 64'd0);
    if (cur_op[1]) begin
      udiv_dout_tvalid = 1'b1;
      udiv_dout        = ip_dout;
    end else begin
      sdiv_dout_tvalid = 1'b1;
      sdiv_dout        = ip_dout;
    end
    tick();
    udiv_dout_tvalid = 1'b0;
    sdiv_dout_tvalid = 1'b0;
    udiv_dout        = $urandom;
    sdiv_dout        = $urandom;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int tr_dly, input int lat, input int rr_dly);
    logic [31:0] exp;
    exp = ref_result(op, a, b);
    start_op(op, a, b);
    handshake(tr_dly);
    deliver(lat);
    check_eq("resp_valid_d1", 64'(resp_valid), 64'd1);
    check_eq("resp_result", 64'(resp_result), 64'(exp));
    repeat (rr_dly) begin
      tick();
      check_eq("resp_hold_valid", 64'({resp_valid, req_ready}), 64'b10);
      check_eq("resp_hold_result", 64'(resp_result), 64'(exp));
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check_eq("idle_after_resp", 64'({resp_valid, busy, req_ready}), 64'b001);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq(tag, {resp_valid, sdiv_tvalid, udiv_tvalid, busy, req_ready, resp_result,
                   div_dividend, div_divisor}, 101'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    resetn = 1'b0;
    req_valid = 1'b0; req_op = 2'b00; req_src1 = '0; req_src2 = '0;
    flush = 1'b0; resp_ready = 1'b0;
    sdiv_tready = 1'b0; udiv_tready = 1'b0;
    sdiv_dout_tvalid = 1'b0; udiv_dout_tvalid = 1'b0;
    sdiv_dout = '0; udiv_dout = '0;
    cur_op = 2'b00; ip_dout = '0;

    #1;
    check_reset_outputs("reset_values");
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    check_eq("ready_after_reset", 64'({req_ready, busy}), 64'b10);

    // signed divide, result 8 cycles after tready
    do_op(2'b00, 32'd100, 32'hFFFF_FFF9, 0, 8, 0);
    check_eq("div_w_100_m7", 64'(resp_result), 64'hFFFF_FFF2);

    // unsigned remainder with a stalled consumer
    do_op(2'b11, 32'hFFFF_FFFF, 32'd16, 1, 3, 3);
    check_eq("mod_wu_const", 64'(resp_result), 64'h0000_000F);

    // request with flush in IDLE is dropped
    req_valid = 1'b1; req_op = 2'b01; req_src1 = 32'd9; req_src2 = 32'd2; flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    check_eq("flush_idle_ignored", 64'({busy, sdiv_tvalid, udiv_tvalid, req_ready}), 64'b0001);

    // flush in ISSUE with tready low: tvalid held, drained, no response
    start_op(2'b00, 32'd1234, 32'd7);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("issue_flush_tvalid", 64'({sdiv_tvalid, busy}), 64'b11);
    check_eq("issue_flush_bus", {div_dividend, div_divisor}, {32'd1234, 32'd7});
    handshake(2);
    check_eq("drain_state", 64'({busy, req_ready, resp_valid}), 64'b100);
    deliver(3);
    check_eq("drain_done", 64'({resp_valid, busy, req_ready}), 64'b001);

    // flush coincident with udiv dout in WAIT
    start_op(2'b11, 32'd77, 32'd5);
    handshake(1);
    tick();
    flush = 1'b1;
    udiv_dout_tvalid = 1'b1;
    udiv_dout = ip_dout;
    check_eq("wait_flush_noresp", 64'(resp_valid), 64'd0);
    tick();
    flush = 1'b0;
    udiv_dout_tvalid = 1'b0;
    check_eq("wait_flush_idle", 64'({resp_valid, busy, req_ready}), 64'b001);
    do_op(2'b10, 32'd1000, 32'd33, 0, 2, 1);

    // flush in WAIT before the result -> drain
    start_op(2'b01, 32'hFFFF_FF00, 32'd10);
    handshake(0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("wait_to_drain", 64'({busy, resp_valid}), 64'b10);
    deliver(4);
    check_eq("wait_drain_idle", 64'({resp_valid, busy, req_ready}), 64'b001);

    // flush in DONE kills the response immediately
    start_op(2'b00, 32'd81, 32'd9);
    handshake(0);
    deliver(1);
    check_eq("done_valid", 64'(resp_valid), 64'd1);
    flush = 1'b1;
    #1;
    check_eq("done_flush_comb", 64'(resp_valid), 64'd0);
    tick();
    flush = 1'b0;
    check_eq("done_flush_idle", 64'({resp_valid, busy, req_ready}), 64'b001);

    // divide-by-zero and overflow pass through
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 2, 0);
    do_op(2'b01, 32'd12345, 32'd0, 1, 1, 0);
    do_op(2'b10, 32'hDEAD_BEEF, 32'd0, 0, 3, 1);

    // randomized ops
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 28);
      if (i % 8 == 3) b = 32'd0;
      if (i % 8 == 5) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      do_op(op, a, b, $urandom_range(0, 3), $urandom_range(1, 10), $urandom_range(0, 3));
    end

`ifdef DIV_RESULT_CACHE_EN
    // repeated div.wu 50/5 answered from the cache
    do_op(2'b10, 32'd50, 32'd5, 0, 4, 0);
    cur_op = 2'b10;
    req_valid = 1'b1; req_op = 2'b10; req_src1 = 32'd50; req_src2 = 32'd5;
    tick();
    req_valid = 1'b0;
    check_eq("cache_hit_valid", 64'({resp_valid, udiv_tvalid, sdiv_tvalid}), 64'b100);
    check_eq("cache_hit_result", 64'(resp_result), 64'd10);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check_eq("cache_hit_idle", 64'({resp_valid, busy, req_ready, udiv_tvalid}), 64'b0010);
`endif

    // reset during WAIT, late dout afterwards is ignored
    start_op(2'b00, 32'd99, 32'd3);
    handshake(0);
    tick();
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("async_reset_wait");
    tick();
    resetn = 1'b1;
    tick();
    sdiv_dout_tvalid = 1'b1;
    sdiv_dout = ip_dout;
    tick();
    sdiv_dout_tvalid = 1'b0;
    check_eq("late_dout_ignored", {resp_valid, sdiv_tvalid, udiv_tvalid, busy, resp_result,
                                   div_dividend, div_divisor}, 100'd0);
    check_eq("ready_after_late", 64'(req_ready), 64'd1);
    do_op(2'b01, 32'd100, 32'd7, 1, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameters: none; width fixed at 32-bit operands, 64-bit divider output.
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  EXE offers a divide op.
REQ-005 req_ready  output  1  controller accepts op (high only in IDLE).
REQ-006 req_op  input  2  00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu.
REQ-007 req_src1 / req_src2  input  32 each  dividend / divisor.
REQ-008 flush  input  1  cancel in-flight op (exception/branch kill).
REQ-009 resp_valid / resp_ready  output / input  1 each  result handshake to EXE.
REQ-010 resp_result  output  32  selected quotient or remainder.
REQ-011 busy  output  1  state != IDLE.
REQ-012 div_dividend / div_divisor  output  32 each  shared operand bus to both divider IPs, registered at accept.
REQ-013 sdiv_tvalid / udiv_tvalid  output  1 each  operand valid to signed / unsigned IP.
REQ-014 sdiv_tready / udiv_tready  input  1 each  AND of IP dividend and divisor tready (formed at top).
REQ-015 sdiv_dout_tvalid / udiv_dout_tvalid  input  1 each; sdiv_dout / udiv_dout  input  64 each  {quotient[63:32], remainder[31:0]}.

Function
REQ-016 States: IDLE, ISSUE, WAIT, DONE, DRAIN.
REQ-017 IDLE: req_valid & ~flush -> latch op/operands, go ISSUE; req_valid & flush -> request ignored, stay IDLE.
REQ-018 ISSUE: assert tvalid of IP chosen by op[1] (0 signed, 1 unsigned); on its tready -> WAIT, or DRAIN if flush seen in ISSUE or that cycle.
REQ-019 tvalid, once high, SHALL stay high with stable operands until tready, even under flush.
REQ-020 WAIT: on selected dout_tvalid latch resp_result (op[0]=1 -> dout[31:0], else dout[63:32]), go DONE; flush -> DRAIN.
REQ-021 Same-cycle flush and dout_tvalid in WAIT -> result discarded, IDLE.
REQ-022 DRAIN: req_ready=0; on selected dout_tvalid -> IDLE, result discarded.
REQ-023 DONE: resp_valid = ~flush; resp_valid & resp_ready -> IDLE; flush -> IDLE, no response.
REQ-024 Latency: accept at T -> tvalid at T+1; dout_tvalid at D -> resp_valid at D+1.
REQ-025 Divide-by-zero and overflow: IP output passed through unmodified.
REQ-026 The unselected IP's tvalid SHALL remain 0.

Reset
REQ-027 On resetn low: state IDLE, req_ready=0 during reset, resp_valid/tvalids/busy=0, resp_result/div_dividend/div_divisor=0, cache invalid; outputs reach these values asynchronously.
REQ-028 Reset mid-operation abandons the IP transaction; any late dout_tvalid in IDLE is ignored.

Configuration
REQ-029 Macro DIV_RESULT_CACHE_EN: when defined, keep one entry {op, src1, src2, result}, written on WAIT->DONE; an IDLE request matching a valid entry goes directly to DONE (resp_valid at T+1), no IP issue; flushed ops never write; without macro every request issues to the IP.

Structure
REQ-030 Package div_ctrl_pkg holds the state enum and req_op encodings.
REQ-031 Optional sub-module div_result_cache (compiled only under DIV_RESULT_CACHE_EN).

Verification
REQ-032 div.w 100 / -7 with IP dout_tvalid 8 cycles after tready -> resp_result 0xFFFFFFF2 (-14) exactly 1 cycle after dout_tvalid.
REQ-033 mod.wu 0xFFFFFFFF / 16 with resp_ready low 3 cycles -> resp_result 0x0000000F held stable, req_ready 0 until handshake.
REQ-034 Flush while sdiv_tready low in ISSUE -> sdiv_tvalid held until tready, DRAIN, no resp_valid, IDLE after dout_tvalid.
REQ-035 Flush coincident with udiv_dout_tvalid in WAIT -> no resp_valid, IDLE next cycle, next request accepted.
REQ-036 With DIV_RESULT_CACHE_EN: repeat div.wu 50 / 5 -> second resp_valid at T+1 with 10, udiv_tvalid never asserted.
REQ-037 resetn low in WAIT, late dout_tvalid after release -> ignored, outputs at reset values.
